// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_if
// Brief    : Issue/result bundle between the execute stage and the MDU.
// Revision : 1.0 - initial release
// ============================================================================
interface md_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        md_op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              busy;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, hi_out, lo_out
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, hi_out, lo_out
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Brief    : Fixed-latency multiply/divide unit with HI/LO registers.
//            Define MDU_MADD_EN to enable MADD/MADDU accumulate ops (6/7).
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    md_unit_if.slave  md
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
    localparam logic [2:0] c_OP_MADD  = 3'd6;
    localparam logic [2:0] c_OP_MADDU = 3'd7;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic [DATA_W-1:0]  r_pend_hi;
    logic [DATA_W-1:0]  r_pend_lo;
    logic               r_pend_wr;

    logic                w_mul_sgn;
    logic [2*DATA_W-1:0] w_ext_a;
    logic [2*DATA_W-1:0] w_ext_b;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_div_sgn;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_b_zero;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W-1:0]   w_den;
    logic [DATA_W-1:0]   w_uq;
    logic [DATA_W-1:0]   w_ur;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    // Sign-extending to 2*DATA_W makes a single modular multiply correct for both signednesses.
    always_comb begin
        w_mul_sgn = (md.md_op == c_OP_MULT) || (md.md_op == c_OP_MADD);
        w_ext_a   = w_mul_sgn ? {{DATA_W{md.src_a[DATA_W-1]}}, md.src_a}
                              : {{DATA_W{1'b0}}, md.src_a};
        w_ext_b   = w_mul_sgn ? {{DATA_W{md.src_b[DATA_W-1]}}, md.src_b}
                              : {{DATA_W{1'b0}}, md.src_b};
        w_prod    = w_ext_a * w_ext_b;
    end

    // Signed divide via magnitudes; MIN/-1 falls out as MIN with zero remainder.
    always_comb begin
        w_div_sgn = (md.md_op == c_OP_DIV);
        w_a_neg   = w_div_sgn && md.src_a[DATA_W-1];
        w_b_neg   = w_div_sgn && md.src_b[DATA_W-1];
        w_b_zero  = (md.src_b == '0);
        w_abs_a   = w_a_neg ? (-md.src_a) : md.src_a;
        w_abs_b   = w_b_neg ? (-md.src_b) : md.src_b;
        w_den     = w_b_zero ? DATA_W'(1) : w_abs_b;
        w_uq      = w_abs_a / w_den;
        w_ur      = w_abs_a % w_den;
        w_quot    = (w_a_neg ^ w_b_neg) ? (-w_uq) : w_uq;
        w_rem     = w_a_neg ? (-w_ur) : w_ur;
    end

`ifdef MDU_MADD_EN
    logic [2*DATA_W-1:0] w_madd_sum;
    assign w_madd_sum = {r_hi, r_lo} + w_prod;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    if (md.start) begin
                        case (md.md_op)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_pend_hi <= w_prod[2*DATA_W-1:DATA_W];
                                r_pend_lo <= w_prod[DATA_W-1:0];
                                r_pend_wr <= 1'b1;
                                r_cnt     <= c_CNT_W'(MULT_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= c_ST_RUN;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                r_pend_hi <= w_rem;
                                r_pend_lo <= w_quot;
                                r_pend_wr <= !w_b_zero;
                                r_cnt     <= c_CNT_W'(DIV_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= c_ST_RUN;
                            end
                            c_OP_MTHI: r_hi <= md.src_a;
                            c_OP_MTLO: r_lo <= md.src_a;
`ifdef MDU_MADD_EN
                            c_OP_MADD, c_OP_MADDU: begin
                                r_pend_hi <= w_madd_sum[2*DATA_W-1:DATA_W];
                                r_pend_lo <= w_madd_sum[DATA_W-1:0];
                                r_pend_wr <= 1'b1;
                                r_cnt     <= c_CNT_W'(MULT_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= c_ST_RUN;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign md.busy   = r_busy;
    assign md.hi_out = r_hi;
    assign md.lo_out = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Brief    : Self-checking bench for md_unit: directed cases plus random ops
//            against an arithmetic HI/LO model. Honours MDU_MADD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit_if #(.DATA_W(32)) md_if ();

    md_unit #(
        .DATA_W      (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one op, computed directly from the ISA rules.
    task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hi, input logic [31:0] lo,
                             output logic [31:0] nh, output logic [31:0] nl, output int lat);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        nh = hi;
        nl = lo;
        lat = 0;
        case (op)
            3'd0: begin sp = longint'(sa) * longint'(sb); {nh, nl} = sp; lat = 5; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; {nh, nl} = up; lat = 5; end
            3'd2: begin
                lat = 10;
                if (b == 0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    nl = 32'h8000_0000;
                    nh = 32'h0;
                end else begin
                    nl = sa / sb;
                    nh = sa % sb;
                end
            end
            3'd3: begin
                lat = 10;
                if (b != 0) begin nl = a / b; nh = a % b; end
            end
            3'd4: nh = a;
            3'd5: nl = a;
            default: begin
`ifdef MDU_MADD_EN
                if (op == 3'd6) begin sp = longint'(sa) * longint'(sb); up = sp; end
                else up = {32'd0, a} * {32'd0, b};
                {nh, nl} = {hi, lo} + up;
                lat = 5;
`endif
            end
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, input string tag);
        logic [31:0] nh, nl;
        int lat;
        int cyc;
        ref_model(op, a, b, m_hi, m_lo, nh, nl, lat);
        @(negedge clk);
        md_if.start = 1'b1;
        md_if.md_op = op;
        md_if.src_a = a;
        md_if.src_b = b;
        @(posedge clk);
        #1;
        md_if.start = 1'b0;
        md_if.src_a = $urandom;
        md_if.src_b = $urandom;
        chk({tag, "_busy_at_issue"}, 64'(md_if.busy), 64'(lat != 0));
        if (lat != 0) begin
            chk({tag, "_hi_hold"}, 64'(md_if.hi_out), 64'(m_hi));
            chk({tag, "_lo_hold"}, 64'(md_if.lo_out), 64'(m_lo));
        end
        cyc = 0;
        while (md_if.busy === 1'b1 && cyc < 40) begin
            if (poke && cyc < 2) begin
                md_if.start = 1'b1;
                md_if.md_op = 3'd3;
                md_if.src_a = 32'd100;
                md_if.src_b = 32'd7;
            end else begin
                md_if.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        md_if.start = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_hi"}, 64'(md_if.hi_out), 64'(nh));
        chk({tag, "_lo"}, 64'(md_if.lo_out), 64'(nl));
        m_hi = nh;
        m_lo = nl;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset       = 1'b1;
        md_if.start = 1'b0;
        md_if.md_op = 3'd0;
        md_if.src_a = '0;
        md_if.src_b = '0;
        #12;
        chk("reset_busy", 64'(md_if.busy), 64'd0);
        chk("reset_hi", 64'(md_if.hi_out), 64'd0);
        chk("reset_lo", 64'(md_if.lo_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
        chk("mult_neg2x3_hi_const", 64'(md_if.hi_out), 64'hFFFF_FFFF);
        chk("mult_neg2x3_lo_const", 64'(md_if.lo_out), 64'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu_max2");
        chk("multu_max2_hi_const", 64'(md_if.hi_out), 64'h1);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7_2");
        chk("div_neg7_2_lo_const", 64'(md_if.lo_out), 64'hFFFF_FFFD);
        chk("div_neg7_2_hi_const", 64'(md_if.hi_out), 64'hFFFF_FFFF);
        run_op(3'd2, 32'd5, 32'd0, 1'b0, "div_by_zero");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1");
        run_op(3'd4, 32'h1234, 32'd0, 1'b0, "mthi");
        run_op(3'd5, 32'h5678, 32'd0, 1'b0, "mtlo");
        chk("mthi_mtlo_hi_const", 64'(md_if.hi_out), 64'h1234);
        run_op(3'd0, 32'd1000, 32'd77, 1'b1, "mult_ignore_divu");

        // Async reset in the middle of a multiply must drop everything at once.
        run_op(3'd4, 32'hCAFE, 32'd0, 1'b0, "pre_reset_mthi");
        @(negedge clk);
        md_if.start = 1'b1;
        md_if.md_op = 3'd0;
        md_if.src_a = 32'd7;
        md_if.src_b = 32'd9;
        @(posedge clk);
        #1;
        md_if.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_busy", 64'(md_if.busy), 64'd0);
        chk("async_reset_hi", 64'(md_if.hi_out), 64'd0);
        chk("async_reset_lo", 64'(md_if.lo_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_reset_busy", 64'(md_if.busy), 64'd0);
        chk("post_reset_hi", 64'(md_if.hi_out), 64'd0);
        chk("post_reset_lo", 64'(md_if.lo_out), 64'd0);
        m_hi = '0;
        m_lo = '0;

        run_op(3'd5, 32'd10, 32'd0, 1'b0, "madd_prep");
        run_op(3'd6, 32'd3, 32'd4, 1'b0, "madd_3x4");
`ifdef MDU_MADD_EN
        chk("madd_3x4_lo_const", 64'(md_if.lo_out), 64'd22);
`else
        chk("madd_3x4_lo_const", 64'(md_if.lo_out), 64'd10);
`endif
        chk("madd_3x4_hi_const", 64'(md_if.hi_out), 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(op, a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
